// File: rtl/mbtrain_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mbtrain_pkg
// Description : Shared definitions for the mainband training sideband
//               sequencer: FSM state encoding and the default sideband
//               message codes used by the request/response handshake.
// Revision    : 1.0 - initial release
// ============================================================================
package mbtrain_pkg;

   // Default sideband message code width
   localparam int c_msg_w = 4;

   // Default request/response codes for the two-step training sequence
   localparam logic [3:0] c_msg_start_req  = 4'b0001;
   localparam logic [3:0] c_msg_start_resp = 4'b0010;
   localparam logic [3:0] c_msg_end_req    = 4'b0011;
   localparam logic [3:0] c_msg_end_resp   = 4'b0100;

   // Sequencer state encoding
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CAL       = 3'd1,
      ST_SEND      = 3'd2,
      ST_WAIT_RESP = 3'd3,
      ST_DONE      = 3'd4,
      ST_ERROR     = 3'd5
   } mbtrain_state_e;

endpackage : mbtrain_pkg
`default_nettype wire

// File: rtl/mbtrain_seq_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : mbtrain_seq_tx_if
// Description : Sideband handshake bundle between the training sequencer and
//               the sideband transmit/receive logic.
//                 i_sideband_valid           decoded partner message valid
//                 i_decoded_sideband_message received partner message code
//                 i_busy_negedge_detected    transmitter finished a message
//                 i_valid_rx                 receive path owns the shared mux
//                 o_sideband_message         request code to transmit
//                 o_valid_tx                 request pending transmission
//               master: sequencer side, slave: sideband logic side.
// Revision    : 1.0 - initial release
// ============================================================================
interface mbtrain_seq_tx_if
   import mbtrain_pkg::*;
#(
   parameter int MSG_W = c_msg_w
);
   logic             i_sideband_valid;
   logic [MSG_W-1:0] i_decoded_sideband_message;
   logic             i_busy_negedge_detected;
   logic             i_valid_rx;
   logic [MSG_W-1:0] o_sideband_message;
   logic             o_valid_tx;

   modport master (
      input  i_sideband_valid,
      input  i_decoded_sideband_message,
      input  i_busy_negedge_detected,
      input  i_valid_rx,
      output o_sideband_message,
      output o_valid_tx
   );

   modport slave (
      output i_sideband_valid,
      output i_decoded_sideband_message,
      output i_busy_negedge_detected,
      output i_valid_rx,
      input  o_sideband_message,
      input  o_valid_tx
   );
endinterface : mbtrain_seq_tx_if
`default_nettype wire

// File: rtl/mbtrain_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module      : mbtrain_timeout_cnt
// Description : Per-attempt response timeout counter. Cleared by i_load,
//               counts while i_enable is high and saturates at the terminal
//               value, where o_expire is asserted.
//   Ports     : clk, rst      clock / synchronous active-high reset
//               i_load        clear the count (has priority over i_enable)
//               i_enable      advance the count this cycle
//               o_expire      count has reached TIMEOUT_CYCLES-1
// Revision    : 1.0 - initial release
// ============================================================================
module mbtrain_timeout_cnt
   import mbtrain_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   input  logic i_enable,
   output logic o_expire
);

   localparam int                 c_cnt_w = $clog2(TIMEOUT_CYCLES);
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(TIMEOUT_CYCLES - 1);

   logic [c_cnt_w-1:0] r_cnt;

   // Saturating: the sequencer always leaves the attempt on expiry, so
   // holding at the terminal value only guards against wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= '0;
      end else if (i_enable && (r_cnt != c_last)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_expire = (r_cnt == c_last);

endmodule : mbtrain_timeout_cnt
`default_nettype wire

// File: rtl/mbtrain_seq_tx.sv
`default_nettype none
// ============================================================================
// Module      : mbtrain_seq_tx
// Description : Mainband training sideband request sequencer. After an
//               enable and a fixed calibration phase it issues N_STEPS
//               request codes in order, each waiting for its matching
//               response code. Unanswered requests are re-sent up to
//               MAX_RETRY times before the run is flagged as an error.
//   Ports     : clk, rst      clock / synchronous active-high reset
//               i_en          run enable; low aborts and idles the block
//               sb            sideband handshake bundle (master side)
//               o_test_ack    all steps completed
//               o_error       a step exhausted its retries
//               o_step        index of the active step
// Revision    : 1.0 - initial release
// ============================================================================
module mbtrain_seq_tx
   import mbtrain_pkg::*;
#(
   parameter int                       MSG_W          = c_msg_w,
   parameter int                       N_STEPS        = 2,
   parameter logic [N_STEPS*MSG_W-1:0] REQ_CODES      = {c_msg_end_req, c_msg_start_req},
   parameter logic [N_STEPS*MSG_W-1:0] RESP_CODES     = {c_msg_end_resp, c_msg_start_resp},
   parameter int                       CAL_CYCLES     = 1,
   parameter int                       TIMEOUT_CYCLES = 1024,
   parameter int                       MAX_RETRY      = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   mbtrain_seq_tx_if.master sb,
   output logic             o_test_ack,
   output logic             o_error,
   output logic [2:0]       o_step
);

   // ------------------------------------------------------------------------
   // Counter widths (a degenerate parameter still gets a 1-bit counter)
   // ------------------------------------------------------------------------
   localparam int c_step_w  = (N_STEPS > 1)    ? $clog2(N_STEPS)       : 1;
   localparam int c_cal_w   = (CAL_CYCLES > 1) ? $clog2(CAL_CYCLES)    : 1;
   localparam int c_retry_w = (MAX_RETRY > 0)  ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [c_step_w-1:0]  c_last_step = c_step_w'(N_STEPS - 1);
   localparam logic [c_cal_w-1:0]   c_last_cal  = c_cal_w'(CAL_CYCLES - 1);
   localparam logic [c_retry_w-1:0] c_max_retry = c_retry_w'(MAX_RETRY);

   // ------------------------------------------------------------------------
   // Per-step code tables unpacked from the flat parameters (step 0 = LSBs)
   // ------------------------------------------------------------------------
   logic [MSG_W-1:0] w_req_tab  [N_STEPS];
   logic [MSG_W-1:0] w_resp_tab [N_STEPS];

   for (genvar k = 0; k < N_STEPS; k++) begin : g_code_tab
      assign w_req_tab[k]  = REQ_CODES[k*MSG_W +: MSG_W];
      assign w_resp_tab[k] = RESP_CODES[k*MSG_W +: MSG_W];
   end

   // ------------------------------------------------------------------------
   // State and registered outputs
   // ------------------------------------------------------------------------
   mbtrain_state_e       r_state;
   logic [c_step_w-1:0]  r_step;
   logic [c_retry_w-1:0] r_retry;
   logic [c_cal_w-1:0]   r_cal;
   logic [MSG_W-1:0]     r_msg;
   logic                 r_valid_tx;
   logic                 r_test_ack;
   logic                 r_error;

   mbtrain_state_e       w_state_nxt;
   logic [c_step_w-1:0]  w_step_nxt;
   logic [c_retry_w-1:0] w_retry_nxt;
   logic [c_cal_w-1:0]   w_cal_nxt;
   logic [MSG_W-1:0]     w_msg_nxt;
   logic                 w_valid_tx_nxt;
   logic                 w_test_ack_nxt;
   logic                 w_error_nxt;

   logic                 w_tmr_load;
   logic                 w_tmr_en;
   logic                 w_expire;
   logic                 w_match;
   logic                 w_tx_done;
   logic [c_step_w-1:0]  w_step_inc;

   // Only a valid message carrying the current step's response code counts;
   // any other valid traffic on the sideband is ignored.
   assign w_match    = sb.i_sideband_valid &&
                       (sb.i_decoded_sideband_message == w_resp_tab[r_step]);

   // The transmitter's busy negedge only retires our request when the shared
   // sideband mux is not held by the receive path.
   assign w_tx_done  = sb.i_busy_negedge_detected && !sb.i_valid_rx;

   assign w_step_inc = r_step + 1'b1;
   assign w_tmr_en   = (r_state == ST_SEND) || (r_state == ST_WAIT_RESP);

   mbtrain_timeout_cnt #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout_cnt (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_tmr_load),
      .i_enable (w_tmr_en),
      .o_expire (w_expire)
   );

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_step     <= '0;
         r_retry    <= '0;
         r_cal      <= '0;
         r_msg      <= '0;
         r_valid_tx <= 1'b0;
         r_test_ack <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_step     <= w_step_nxt;
         r_retry    <= w_retry_nxt;
         r_cal      <= w_cal_nxt;
         r_msg      <= w_msg_nxt;
         r_valid_tx <= w_valid_tx_nxt;
         r_test_ack <= w_test_ack_nxt;
         r_error    <= w_error_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt    = r_state;
      w_step_nxt     = r_step;
      w_retry_nxt    = r_retry;
      w_cal_nxt      = r_cal;
      w_msg_nxt      = r_msg;
      w_valid_tx_nxt = r_valid_tx;
      w_test_ack_nxt = r_test_ack;
      w_error_nxt    = r_error;
      w_tmr_load     = 1'b0;

      if (!i_en) begin
         // Disable aborts from any state back to a clean idle
         w_state_nxt    = ST_IDLE;
         w_step_nxt     = '0;
         w_retry_nxt    = '0;
         w_cal_nxt      = '0;
         w_msg_nxt      = '0;
         w_valid_tx_nxt = 1'b0;
         w_test_ack_nxt = 1'b0;
         w_error_nxt    = 1'b0;
         w_tmr_load     = 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_nxt = ST_CAL;
               w_step_nxt  = '0;
               w_retry_nxt = '0;
               w_cal_nxt   = '0;
               w_tmr_load  = 1'b1;
            end

            ST_CAL: begin
               if (r_cal == c_last_cal) begin
                  w_state_nxt    = ST_SEND;
                  w_msg_nxt      = w_req_tab[r_step];
                  w_valid_tx_nxt = 1'b1;
                  w_tmr_load     = 1'b1;
               end else begin
                  w_cal_nxt = r_cal + 1'b1;
               end
            end

            ST_SEND, ST_WAIT_RESP: begin
               // Match is checked first so a response arriving on the
               // timeout cycle still completes the step.
               if (w_match) begin
                  if (r_step == c_last_step) begin
                     w_state_nxt    = ST_DONE;
                     w_test_ack_nxt = 1'b1;
                     w_msg_nxt      = '0;
                     w_valid_tx_nxt = 1'b0;
                  end else begin
                     w_state_nxt    = ST_SEND;
                     w_step_nxt     = w_step_inc;
                     w_retry_nxt    = '0;
                     w_msg_nxt      = w_req_tab[w_step_inc];
                     w_valid_tx_nxt = 1'b1;
                     w_tmr_load     = 1'b1;
                  end
               end else if (w_expire) begin
                  if (r_retry == c_max_retry) begin
                     w_state_nxt    = ST_ERROR;
                     w_error_nxt    = 1'b1;
                     w_valid_tx_nxt = 1'b0;
                  end else begin
                     // Re-send the same step's request
                     w_state_nxt    = ST_SEND;
                     w_retry_nxt    = r_retry + 1'b1;
                     w_msg_nxt      = w_req_tab[r_step];
                     w_valid_tx_nxt = 1'b1;
                     w_tmr_load     = 1'b1;
                  end
               end else if ((r_state == ST_SEND) && w_tx_done) begin
                  w_state_nxt    = ST_WAIT_RESP;
                  w_valid_tx_nxt = 1'b0;
               end
            end

            ST_DONE, ST_ERROR: begin
               // Terminal: hold everything until the enable drops
            end

            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign sb.o_sideband_message = r_msg;
   assign sb.o_valid_tx         = r_valid_tx;
   assign o_test_ack            = r_test_ack;
   assign o_error               = r_error;
   assign o_step                = 3'(r_step);

endmodule : mbtrain_seq_tx
`default_nettype wire

// File: tb/tb_mbtrain_seq_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_mbtrain_seq_tx
// Description : Self-checking bench for mbtrain_seq_tx. Two instances with
//               different calibration/timeout/retry settings are compared
//               every cycle against a transaction-level reference model,
//               with directed scenarios followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mbtrain_seq_tx;
   import mbtrain_pkg::*;

   localparam int CAL_A = 3, TO_A = 1024, MR_A = 2;
   localparam int CAL_B = 1, TO_B = 16,   MR_B = 1;

   localparam int M_IDLE = 0, M_CAL = 1, M_SEND = 2, M_WAIT = 3, M_DONE = 4, M_ERR = 5;

   // Reference model: what the sequencer is doing, in protocol terms
   typedef struct {
      int         mode;
      int         step;   // which request/response pair is in flight
      int         retry;  // re-sends already spent on this step
      int         cal;    // calibration cycles already elapsed
      int         age;    // cycles since the current request was issued
      logic [3:0] msg;
      logic       vtx;
      logic       ack;
      logic       err;
   } mdl_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       en_a, en_b;
   logic       ack_a, err_a, ack_b, err_b;
   logic [2:0] step_a, step_b;

   mdl_t ma, mb;
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   cyc    = 0;

   mbtrain_seq_tx_if #(.MSG_W(4)) ifa ();
   mbtrain_seq_tx_if #(.MSG_W(4)) ifb ();

   always #5 clk = ~clk;

   mbtrain_seq_tx #(.CAL_CYCLES(CAL_A), .TIMEOUT_CYCLES(TO_A), .MAX_RETRY(MR_A)) dut_a (
      .clk(clk), .rst(rst), .i_en(en_a), .sb(ifa),
      .o_test_ack(ack_a), .o_error(err_a), .o_step(step_a));

   mbtrain_seq_tx #(.CAL_CYCLES(CAL_B), .TIMEOUT_CYCLES(TO_B), .MAX_RETRY(MR_B)) dut_b (
      .clk(clk), .rst(rst), .i_en(en_b), .sb(ifb),
      .o_test_ack(ack_b), .o_error(err_b), .o_step(step_b));

   // ------------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------------
   function automatic logic [3:0] req_of(int s);
      return (s == 0) ? 4'b0001 : 4'b0011;
   endfunction

   function automatic logic [3:0] resp_of(int s);
      return (s == 0) ? 4'b0010 : 4'b0100;
   endfunction

   function automatic mdl_t idle_m();
      mdl_t m;
      m.mode = M_IDLE; m.step = 0; m.retry = 0; m.cal = 0; m.age = 0;
      m.msg = 4'd0; m.vtx = 1'b0; m.ack = 1'b0; m.err = 1'b0;
      return m;
   endfunction

   function automatic mdl_t issue(mdl_t m);
      m.mode = M_SEND; m.msg = req_of(m.step); m.vtx = 1'b1; m.age = 0;
      return m;
   endfunction

   function automatic mdl_t advance(mdl_t m, int cal_n, int to_n, int mr_n, logic r,
                                    logic en, logic sv, logic [3:0] rx, logic bn, logic vrx);
      mdl_t n;
      n = m;
      if (r || !en) return idle_m();
      case (m.mode)
         M_IDLE: begin
            n.mode = M_CAL; n.cal = 0; n.step = 0; n.retry = 0;
         end
         M_CAL: begin
            if (m.cal + 1 >= cal_n) n = issue(n);
            else n.cal = m.cal + 1;
         end
         M_SEND, M_WAIT: begin
            if (sv && rx == resp_of(m.step)) begin
               if (m.step == 1) begin
                  n.mode = M_DONE; n.ack = 1'b1; n.msg = 4'd0; n.vtx = 1'b0;
               end else begin
                  n.step = m.step + 1; n.retry = 0; n = issue(n);
               end
            end else if (m.age == to_n - 1) begin
               if (m.retry == mr_n) begin
                  n.mode = M_ERR; n.err = 1'b1; n.vtx = 1'b0;
               end else begin
                  n.retry = m.retry + 1; n = issue(n);
               end
            end else begin
               n.age = m.age + 1;
               if (m.mode == M_SEND && bn && !vrx) begin
                  n.vtx = 1'b0; n.mode = M_WAIT;
               end
            end
         end
         default: ;
      endcase
      return n;
   endfunction

   // ------------------------------------------------------------------------
   // Checking helpers
   // ------------------------------------------------------------------------
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic check_dut(input string id, input logic [3:0] msg, input logic vtx,
                            input logic ack, input logic err, input logic [2:0] st, input mdl_t m);
      chk({id, ".msg"},  {4'd0, msg}, {4'd0, m.msg});
      chk({id, ".vtx"},  {7'd0, vtx}, {7'd0, m.vtx});
      chk({id, ".ack"},  {7'd0, ack}, {7'd0, m.ack});
      chk({id, ".err"},  {7'd0, err}, {7'd0, m.err});
      chk({id, ".step"}, {5'd0, st},  8'(m.step));
   endtask

   // Advance one clock: model sees the same inputs the DUTs sample
   task automatic tick();
      mdl_t na, nb;
      na = advance(ma, CAL_A, TO_A, MR_A, rst, en_a, ifa.i_sideband_valid,
                   ifa.i_decoded_sideband_message, ifa.i_busy_negedge_detected, ifa.i_valid_rx);
      nb = advance(mb, CAL_B, TO_B, MR_B, rst, en_b, ifb.i_sideband_valid,
                   ifb.i_decoded_sideband_message, ifb.i_busy_negedge_detected, ifb.i_valid_rx);
      @(posedge clk);
      #1;
      cyc++;
      ma = na;
      mb = nb;
      check_dut("a", ifa.o_sideband_message, ifa.o_valid_tx, ack_a, err_a, step_a, ma);
      check_dut("b", ifb.o_sideband_message, ifb.o_valid_tx, ack_b, err_b, step_b, mb);
   endtask

   task automatic idle_in();
      ifa.i_sideband_valid = 1'b0; ifa.i_decoded_sideband_message = 4'd0;
      ifa.i_busy_negedge_detected = 1'b0; ifa.i_valid_rx = 1'b0;
      ifb.i_sideband_valid = 1'b0; ifb.i_decoded_sideband_message = 4'd0;
      ifb.i_busy_negedge_detected = 1'b0; ifb.i_valid_rx = 1'b0;
   endtask

   // Bounded wait for o_valid_tx (c=0: dut_a, c=1: dut_b); returns the cycle
   task automatic wait_vtx(input int c, output int t);
      t = -1;
      for (int i = 0; i < 100; i++) begin
         tick();
         if ((c == 0) ? ifa.o_valid_tx : ifb.o_valid_tx) begin
            t = cyc;
            return;
         end
      end
      n_cmp++; n_fail++;
      $error("FAIL wait_vtx%0d observed=timeout expected=valid_tx", c);
   endtask

   task automatic wait_err_b(output int t);
      t = -1;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (err_b) begin
            t = cyc;
            return;
         end
      end
      n_cmp++; n_fail++;
      $error("FAIL wait_err_b observed=timeout expected=error");
   endtask

   task automatic drive_rand(input int c);
      mdl_t       m;
      logic       en, sv, bn, vrx;
      logic [3:0] rx;
      if (c == 0) begin m = ma; en = en_a; end
      else begin m = mb; en = en_b; end
      if (!en) en = ($urandom_range(0, 3) == 0);
      else if ((m.mode == M_DONE || m.mode == M_ERR) && $urandom_range(0, 3) == 0) en = 1'b0;
      else en = ($urandom_range(0, 299) != 0);
      bn  = ($urandom_range(0, 2) == 0);
      vrx = ($urandom_range(0, 3) == 0);
      sv  = ($urandom_range(0, 4) == 0);
      rx  = 4'($urandom_range(0, 15));
      if ((m.mode == M_SEND || m.mode == M_WAIT) &&
          $urandom_range(0, (c == 0) ? 5 : 11) == 0) begin
         sv = 1'b1;
         rx = resp_of(m.step);
      end
      if (c == 0) begin
         en_a = en; ifa.i_sideband_valid = sv; ifa.i_decoded_sideband_message = rx;
         ifa.i_busy_negedge_detected = bn; ifa.i_valid_rx = vrx;
      end else begin
         en_b = en; ifb.i_sideband_valid = sv; ifb.i_decoded_sideband_message = rx;
         ifb.i_busy_negedge_detected = bn; ifb.i_valid_rx = vrx;
      end
   endtask

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin
      int t0, t1, t2, t3, te;

      rst = 1'b1; en_a = 1'b0; en_b = 1'b0;
      idle_in();
      ma = idle_m(); mb = idle_m();
      repeat (3) tick();

      // Reset has priority over enable
      en_a = 1'b1; en_b = 1'b1;
      tick();
      chk("rst.vtx_a", {7'd0, ifa.o_valid_tx}, 8'd0);
      chk("rst.step_a", {5'd0, step_a}, 8'd0);
      chk("rst.err_b", {7'd0, err_b}, 8'd0);
      en_a = 1'b0; en_b = 1'b0;
      rst = 1'b0;
      tick();

      // Full two-step run, 4-cycle request latency with 3 calibration cycles
      en_a = 1'b1;
      t0 = cyc;
      wait_vtx(0, t1);
      chk("run.latency", 8'(t1 - t0), 8'd4);
      chk("run.msg0", {4'd0, ifa.o_sideband_message}, 8'h01);
      tick();
      ifa.i_busy_negedge_detected = 1'b1; tick(); ifa.i_busy_negedge_detected = 1'b0;
      chk("run.vtx_clear", {7'd0, ifa.o_valid_tx}, 8'd0);
      ifa.i_sideband_valid = 1'b1; ifa.i_decoded_sideband_message = 4'b0010;
      tick();
      ifa.i_sideband_valid = 1'b0;
      chk("run.msg1", {4'd0, ifa.o_sideband_message}, 8'h03);
      chk("run.step1", {5'd0, step_a}, 8'd1);
      ifa.i_busy_negedge_detected = 1'b1; tick(); ifa.i_busy_negedge_detected = 1'b0;
      ifa.i_sideband_valid = 1'b1; ifa.i_decoded_sideband_message = 4'b0100;
      tick();
      ifa.i_sideband_valid = 1'b0;
      chk("run.ack", {7'd0, ack_a}, 8'd1);
      repeat (3) tick();
      chk("run.ack_hold", {7'd0, ack_a}, 8'd1);
      en_a = 1'b0; tick();
      chk("run.ack_drop", {7'd0, ack_a}, 8'd0);

      // Receive path holding the mux keeps the request pending
      en_a = 1'b1;
      wait_vtx(0, t1);
      ifa.i_busy_negedge_detected = 1'b1; ifa.i_valid_rx = 1'b1;
      repeat (3) tick();
      chk("mux.vtx_held", {7'd0, ifa.o_valid_tx}, 8'd1);
      ifa.i_valid_rx = 1'b0;
      tick();
      ifa.i_busy_negedge_detected = 1'b0;
      chk("mux.vtx_clear", {7'd0, ifa.o_valid_tx}, 8'd0);

      // Wrong response ignored, right one advances
      ifa.i_sideband_valid = 1'b1; ifa.i_decoded_sideband_message = 4'b0100;
      tick();
      chk("wrong.step", {5'd0, step_a}, 8'd0);
      ifa.i_decoded_sideband_message = 4'b0010;
      tick();
      ifa.i_sideband_valid = 1'b0;
      chk("right.step", {5'd0, step_a}, 8'd1);

      // Abort by enable in WAIT_RESP, then by reset in SEND
      ifa.i_busy_negedge_detected = 1'b1; tick(); ifa.i_busy_negedge_detected = 1'b0;
      en_a = 1'b0; tick();
      chk("abort.en_step", {5'd0, step_a}, 8'd0);
      chk("abort.en_msg", {4'd0, ifa.o_sideband_message}, 8'd0);
      en_a = 1'b1;
      wait_vtx(0, t1);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("abort.rst_vtx", {7'd0, ifa.o_valid_tx}, 8'd0);
      chk("abort.rst_msg", {4'd0, ifa.o_sideband_message}, 8'd0);
      t0 = cyc;
      wait_vtx(0, t1);
      chk("restart.latency", 8'(t1 - t0), 8'd4);
      chk("restart.step", {5'd0, step_a}, 8'd0);
      chk("restart.msg", {4'd0, ifa.o_sideband_message}, 8'h01);
      en_a = 1'b0; tick();

      // No response: one re-send 16 cycles later, error 16 after that
      en_b = 1'b1; ifb.i_busy_negedge_detected = 1'b1;
      wait_vtx(1, t1);
      wait_vtx(1, t2);
      wait_err_b(te);
      chk("to.resend_gap", 8'(t2 - t1), 8'd16);
      chk("to.error_gap", 8'(te - t2), 8'd16);
      chk("to.ack", {7'd0, ack_b}, 8'd0);
      en_b = 1'b0; tick();

      // Response on the timeout cycle of the last attempt still matches
      en_b = 1'b1;
      wait_vtx(1, t1);
      wait_vtx(1, t2);
      repeat (TO_B - 1) tick();
      ifb.i_sideband_valid = 1'b1; ifb.i_decoded_sideband_message = 4'b0010;
      tick();
      ifb.i_sideband_valid = 1'b0;
      t3 = cyc;
      chk("race.step", {5'd0, step_b}, 8'd1);
      chk("race.err", {7'd0, err_b}, 8'd0);
      chk("race.msg", {4'd0, ifb.o_sideband_message}, 8'h03);
      wait_err_b(te);
      chk("race.retry_cleared", 8'(te - t3), 8'd32);
      en_b = 1'b0; ifb.i_busy_negedge_detected = 1'b0; tick();

      // Randomized traffic on both instances
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 499) == 0);
         drive_rand(0);
         drive_rand(1);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog observed=no_finish expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_mbtrain_seq_tx
`default_nettype wire
